// File: rtl/fnd_pkg.sv
// Shared constants and types for the FND scan decoder: segment patterns,
// digit-select codes, FSM state and small decode helpers.
package fnd_pkg;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam logic [3:0] COM_D0    = 4'b1110;
  localparam logic [3:0] COM_D1    = 4'b1101;
  localparam logic [3:0] COM_D2    = 4'b1011;
  localparam logic [3:0] COM_D3    = 4'b0111;
  localparam logic [3:0] COM_BLANK = 4'b1111;

  typedef enum logic {
    ST_SYNC = 1'b0,
    ST_SCAN = 1'b1
  } fnd_state_e;

  typedef struct packed {
    logic       hit;      // exactly one digit selected
    logic [1:0] idx;
    logic       illegal;  // neither one-hot-low nor blank
  } com_dec_t;

  function automatic com_dec_t com_decode(input logic [3:0] com);
    com_dec_t r;
    r.hit     = 1'b1;
    r.idx     = 2'd0;
    r.illegal = 1'b0;
    case (com)
      COM_D0:    r.idx = 2'd0;
      COM_D1:    r.idx = 2'd1;
      COM_D2:    r.idx = 2'd2;
      COM_D3:    r.idx = 2'd3;
      COM_BLANK: r.hit = 1'b0;
      default: begin
        r.hit     = 1'b0;
        r.illegal = 1'b1;
      end
    endcase
    return r;
  endfunction

  function automatic logic [13:0] bcd_to_bin(input logic [3:0][3:0] d);
    return 14'(d[3]) * 14'd1000 + 14'(d[2]) * 14'd100 +
           14'(d[1]) * 14'd10   + 14'(d[0]);
  endfunction

endpackage

// File: rtl/seg_to_bcd.sv
// Active-low 7-segment pattern to BCD digit, with decimal point and
// invalid flag. The dp bit is masked before matching the digit table.
module seg_to_bcd
  import fnd_pkg::*;
(
  input  logic [7:0] seg_i,
  output logic [3:0] digit_o,
  output logic       dp_o,
  output logic       invalid_o
);

  always_comb begin
    digit_o   = 4'd0;
    invalid_o = 1'b0;
    dp_o      = ~seg_i[7];
    case (seg_i | 8'h80)
      SEG_0:     digit_o = 4'd0;
      SEG_1:     digit_o = 4'd1;
      SEG_2:     digit_o = 4'd2;
      SEG_3:     digit_o = 4'd3;
      SEG_4:     digit_o = 4'd4;
      SEG_5:     digit_o = 4'd5;
      SEG_6:     digit_o = 4'd6;
      SEG_7:     digit_o = 4'd7;
      SEG_8:     digit_o = 4'd8;
      SEG_9:     digit_o = 4'd9;
      // a blank digit is only legal with everything dark; a lone dp is garbage
      SEG_BLANK: invalid_o = ~seg_i[7];
      default:   invalid_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/fnd_scan_decoder.sv
// Recovers a 4-digit BCD frame from a multiplexed active-low FND bus by
// debouncing each digit select and assembling digit0..digit3 in order.
module fnd_scan_decoder
  import fnd_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  fnd_data,
  input  logic [3:0]  fnd_com,
  output logic [15:0] digits,
  output logic [3:0]  dp,
  output logic [13:0] value,
  output logic        frame_valid,
  output logic        frame_err
);

  localparam logic [7:0] CNT_HIT = 8'(STABLE_CYCLES - 1);

  logic [7:0]       data_q;
  logic [3:0]       com_q;
  logic [7:0]       cnt_q, cnt_d;
  logic             capt_q, capt_d;
  fnd_state_e       state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0][3:0]  stage_q, stage_d;
  logic [3:0]       sdp_q, sdp_d;
  logic [15:0]      digits_q;
  logic [3:0]       dp_q;
  logic [13:0]      value_q;
  logic             fv_q, fe_q;

  logic [3:0]       seg_dig;
  logic             seg_dp, seg_inv;
  com_dec_t         cd;
  logic             stable_now, cap, bad_com, done, err;

  seg_to_bcd u_seg (
    .seg_i     (data_q),
    .digit_o   (seg_dig),
    .dp_o      (seg_dp),
    .invalid_o (seg_inv)
  );

  // cnt_q counts how many further samples matched the one now in the
  // input register, so it reaches STABLE_CYCLES-1 while that sample is held
  always_comb begin
    cnt_d = 8'd0;
    if ({fnd_com, fnd_data} == {com_q, data_q})
      cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
  end

  assign cd         = com_decode(com_q);
  assign stable_now = (cnt_q == CNT_HIT) && !capt_q;
  assign cap        = stable_now && cd.hit;
  assign bad_com    = stable_now && cd.illegal;
  assign capt_d     = (fnd_com != com_q) ? 1'b0 : (capt_q | stable_now);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    stage_d = stage_q;
    sdp_d   = sdp_q;
    done    = 1'b0;
    err     = 1'b0;
    case (state_q)
      ST_SYNC: begin
        if (cap && cd.idx == 2'd0 && !seg_inv) begin
          stage_d[0] = seg_dig;
          sdp_d[0]   = seg_dp;
          idx_d      = 2'd1;
          state_d    = ST_SCAN;
        end
      end
      default: begin
        if (bad_com || (cap && (seg_inv || cd.idx != idx_q))) begin
          err     = 1'b1;
          idx_d   = 2'd0;
          state_d = ST_SYNC;
        end else if (cap) begin
          stage_d[idx_q] = seg_dig;
          sdp_d[idx_q]   = seg_dp;
          if (idx_q == 2'd3) begin
            done    = 1'b1;
            idx_d   = 2'd0;
            state_d = ST_SYNC;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q   <= SEG_BLANK;
      com_q    <= COM_BLANK;
      cnt_q    <= 8'd0;
      capt_q   <= 1'b0;
      state_q  <= ST_SYNC;
      idx_q    <= 2'd0;
      stage_q  <= '0;
      sdp_q    <= 4'h0;
      digits_q <= 16'h0000;
      dp_q     <= 4'h0;
      value_q  <= 14'd0;
      fv_q     <= 1'b0;
      fe_q     <= 1'b0;
    end else begin
      data_q  <= fnd_data;
      com_q   <= fnd_com;
      cnt_q   <= cnt_d;
      capt_q  <= capt_d;
      state_q <= state_d;
      idx_q   <= idx_d;
      stage_q <= stage_d;
      sdp_q   <= sdp_d;
      fv_q    <= done;
      fe_q    <= err;
      if (done) begin
        digits_q <= stage_d;
        dp_q     <= sdp_d;
        value_q  <= bcd_to_bin(stage_d);
      end
    end
  end

  assign digits      = digits_q;
  assign dp          = dp_q;
  assign value       = value_q;
  assign frame_valid = fv_q;
  assign frame_err   = fe_q;

endmodule

// File: tb/tb_fnd_scan_decoder.sv
// Bench for fnd_scan_decoder: directed scans plus random hold sequences,
// compared against a hold-level frame model.
module tb_fnd_scan_decoder;

  localparam int S = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  fnd_data = 8'hFF;
  logic [3:0]  fnd_com = 4'hF;
  logic [15:0] digits;
  logic [3:0]  dp;
  logic [13:0] value;
  logic        frame_valid, frame_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  fnd_scan_decoder #(.STABLE_CYCLES(S)) dut (
    .clk(clk), .reset(reset), .fnd_data(fnd_data), .fnd_com(fnd_com),
    .digits(digits), .dp(dp), .value(value),
    .frame_valid(frame_valid), .frame_err(frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          c;
    logic [15:0] dg;
    logic [3:0]  dpv;
    int          val;
  } frame_t;

  frame_t exp_fq[$];
  frame_t obs_fq[$];
  int     exp_eq[$];
  int     obs_eq[$];

  logic [7:0] segtab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                              8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  bit          m_scan;
  int          m_next;
  int          m_d [4];
  bit          m_dp [4];
  logic [15:0] m_last_dg;
  logic [3:0]  m_last_dp;
  int          m_last_val;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int tb_decode(input logic [7:0] d);
    if (d == 8'hFF) return 0;
    for (int i = 0; i < 10; i++)
      if ((d | 8'h80) == segtab[i]) return i;
    return -1;
  endfunction

  function automatic int com_idx(input logic [3:0] c);
    logic [3:0] m;
    if (c == 4'hF) return -2;
    for (int k = 0; k < 4; k++) begin
      m = 4'b0001 << k;
      if (c == ~m) return k;
    end
    return -1;
  endfunction

  // one hold = one (com, data) pair presented for len cycles starting at st
  task automatic model_hold(input logic [3:0] com, input logic [7:0] data,
                            input int len, input int st);
    int k, v;
    frame_t f;
    if (len < S) return;
    k = com_idx(com);
    v = tb_decode(data);
    if (k == -2) return;
    if (!m_scan) begin
      if (k == 0 && v >= 0) begin
        m_d[0] = v; m_dp[0] = !data[7]; m_scan = 1; m_next = 1;
      end
    end else if (k < 0 || v < 0 || k != m_next) begin
      exp_eq.push_back(st + S + 1);
      m_scan = 0;
    end else begin
      m_d[k] = v; m_dp[k] = !data[7];
      if (k == 3) begin
        f.c   = st + S + 1;
        f.val = m_d[3] * 1000 + m_d[2] * 100 + m_d[1] * 10 + m_d[0];
        f.dg  = {4'(m_d[3]), 4'(m_d[2]), 4'(m_d[1]), 4'(m_d[0])};
        f.dpv = {m_dp[3], m_dp[2], m_dp[1], m_dp[0]};
        exp_fq.push_back(f);
        m_last_dg = f.dg; m_last_dp = f.dpv; m_last_val = f.val;
        m_scan = 0;
      end else begin
        m_next++;
      end
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (frame_valid) begin
        obs_fq.push_back('{cyc, digits, dp, int'(value)});
        chk("value_vs_digits", 32'(value),
            digits[15:12] * 1000 + digits[11:8] * 100 + digits[7:4] * 10 + 32'(digits[3:0]));
      end
      if (frame_err) obs_eq.push_back(cyc);
    end
  end

  task automatic apply(input logic [3:0] com, input logic [7:0] data, input int len);
    fnd_com  = com;
    fnd_data = data;
    model_hold(com, data, len, cyc);
    repeat (len) @(posedge clk);
    #1;
  endtask

  task automatic scan4(input int n, input int hold);
    int dv;
    logic [3:0] c;
    for (int k = 0; k < 4; k++) begin
      dv = (k == 0) ? n % 10 : (k == 1) ? (n / 10) % 10 : (k == 2) ? (n / 100) % 10 : n / 1000;
      c = ~(4'b0001 << k);
      apply(c, segtab[dv], hold);
      apply(4'hF, 8'hFF, 2);
    end
  endtask

  task automatic flush(input string tag);
    int n;
    apply(4'hF, 8'hFF, S + 4);
    chk({tag, "_nframes"}, obs_fq.size(), exp_fq.size());
    n = (obs_fq.size() < exp_fq.size()) ? obs_fq.size() : exp_fq.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, "_fv_cycle"}, obs_fq[i].c, exp_fq[i].c);
      chk({tag, "_digits"},   32'(obs_fq[i].dg), 32'(exp_fq[i].dg));
      chk({tag, "_dp"},       32'(obs_fq[i].dpv), 32'(exp_fq[i].dpv));
      chk({tag, "_value"},    obs_fq[i].val, exp_fq[i].val);
    end
    chk({tag, "_nerrs"}, obs_eq.size(), exp_eq.size());
    n = (obs_eq.size() < exp_eq.size()) ? obs_eq.size() : exp_eq.size();
    for (int i = 0; i < n; i++)
      chk({tag, "_err_cycle"}, obs_eq[i], exp_eq[i]);
    chk({tag, "_hold_digits"}, 32'(digits), 32'(m_last_dg));
    chk({tag, "_hold_dp"},     32'(dp), 32'(m_last_dp));
    chk({tag, "_hold_value"},  32'(value), m_last_val);
    exp_fq.delete(); obs_fq.delete(); exp_eq.delete(); obs_eq.delete();
  endtask

  task automatic do_reset();
    reset    = 1'b0;
    fnd_com  = 4'hF;
    fnd_data = 8'hFF;
    @(negedge clk);
    chk("rst_digits", 32'(digits), 0);
    chk("rst_dp",     32'(dp), 0);
    chk("rst_value",  32'(value), 0);
    chk("rst_fv",     32'(frame_valid), 0);
    chk("rst_fe",     32'(frame_err), 0);
    m_scan = 0; m_next = 0;
    m_last_dg = 16'h0; m_last_dp = 4'h0; m_last_val = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  initial begin
    int r, L;
    logic [3:0] c, prev;
    logic [7:0] d;
    int seq;

    do_reset();

    scan4(1234, 6);
    flush("scan1234");
    chk("d1234_digits", 32'(digits), 32'h1234);
    chk("d1234_value",  32'(value), 1234);

    scan4(5678, S - 1);
    flush("short_hold");

    apply(4'b1110, segtab[1], 6);
    apply(4'b1011, segtab[2], 6);
    flush("out_of_order");

    apply(4'b1110, segtab[5], 6);
    apply(4'b1101, 8'h7F, 6);
    flush("dp_only_scan");
    apply(4'b1101, 8'h7F, 6);
    apply(4'b1110, 8'h7F, 6);
    flush("dp_only_sync");

    apply(4'b1011, segtab[7], 6);
    apply(4'hF, 8'hFF, 2);
    scan4(510, 6);
    flush("start_mid");
    chk("d510_value", 32'(value), 510);

    apply(4'b1110, segtab[9], 6);
    apply(4'b1101, segtab[9], 6);
    do_reset();
    scan4(42, 6);
    flush("reset_mid");
    chk("d42_value", 32'(value), 42);

    apply(4'b1110, segtab[3], 6);
    apply(4'b1001, segtab[3], S);
    flush("illegal_com");

    seq = 0;
    prev = 4'hF;
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      if (r < 70) begin
        c = ~(4'b0001 << seq);
        seq = (seq + 1) % 4;
      end else if (r < 80) c = 4'hF;
      else if (r < 90) c = ~(4'b0001 << $urandom_range(0, 3));
      else c = 4'($urandom);
      if (c == prev) c = 4'hF;
      d = ($urandom_range(0, 99) < 85) ? segtab[$urandom_range(0, 9)] : 8'($urandom);
      d[7] = 1'($urandom_range(0, 1));
      L = ($urandom_range(0, 3) == 0) ? S - 1 : S + $urandom_range(0, 2);
      apply(c, d, L);
      prev = c;
      if (n % 50 == 49) begin
        flush("random");
        prev = 4'hF;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
